// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush/hold handling and a saturating count of hazard bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_PC,
    input  logic [DATA_W-1:0] id_RD1,
    input  logic [DATA_W-1:0] id_RD2,
    input  logic [DATA_W-1:0] id_ImmG,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [1:0]        id_ALUOp,
    input  logic [2:0]        id_Funct3,
    input  logic [6:0]        id_Funct7,
    input  logic [5:0]        id_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_PC,
    output logic [DATA_W-1:0] ex_RD1,
    output logic [DATA_W-1:0] ex_RD2,
    output logic [DATA_W-1:0] ex_ImmG,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [1:0]        ex_ALUOp,
    output logic [2:0]        ex_Funct3,
    output logic [6:0]        ex_Funct7,
    output logic [5:0]        ex_ctrl,
    output logic              stall,
    output logic [31:0]       bubble_cnt
);

    // id_ctrl / ex_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch}
    localparam int MEM_READ_BIT = 4;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [1:0]        alu_op;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [5:0]        ctrl;
    } ex_stage_t;

    ex_stage_t   stage_d;
    ex_stage_t   stage_q;
    logic [31:0] bubble_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic        rs1_match;
    logic        rs2_match;
    logic        hazard;

    always_comb begin
        rs1_match = id_use_rs1 && (id_rs1 == stage_q.rd);
        rs2_match = id_use_rs2 && (id_rs2 == stage_q.rd);
        hazard    = id_valid && stage_q.valid && stage_q.ctrl[MEM_READ_BIT]
                    && (stage_q.rd != '0) && (rs1_match || rs2_match);
        stall     = ex_hold || (hazard && !flush);
    end

    // Flush beats hold so a taken branch still kills the instruction in EX;
    // an all-zero bubble decodes as ALUOp=00 (ADD) with no side effects.
    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            stage_d = '0;
        end else if (ex_hold) begin
            stage_d = stage_q;
        end else if (hazard) begin
            stage_d = '0;
            if (bubble_cnt_q != 32'hFFFF_FFFF) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end else begin
            stage_d.valid  = id_valid;
            stage_d.pc     = id_PC;
            stage_d.rd1    = id_RD1;
            stage_d.rd2    = id_RD2;
            stage_d.imm    = id_ImmG;
            stage_d.rs1    = id_rs1;
            stage_d.rs2    = id_rs2;
            stage_d.rd     = id_rd;
            stage_d.alu_op = id_ALUOp;
            stage_d.funct3 = id_Funct3;
            stage_d.funct7 = id_Funct7;
            stage_d.ctrl   = id_valid ? id_ctrl : 6'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = stage_q.valid;
    assign ex_PC      = stage_q.pc;
    assign ex_RD1     = stage_q.rd1;
    assign ex_RD2     = stage_q.rd2;
    assign ex_ImmG    = stage_q.imm;
    assign ex_rs1     = stage_q.rs1;
    assign ex_rs2     = stage_q.rs2;
    assign ex_rd      = stage_q.rd;
    assign ex_ALUOp   = stage_q.alu_op;
    assign ex_Funct3  = stage_q.funct3;
    assign ex_Funct7  = stage_q.funct7;
    assign ex_ctrl    = stage_q.ctrl;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a rule-level model.
module tb_id_ex_stage;

    typedef logic [191:0] chk_t;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_PC, id_RD1, id_RD2, id_ImmG;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [1:0]  id_ALUOp;
    logic [2:0]  id_Funct3;
    logic [6:0]  id_Funct7;
    logic [5:0]  id_ctrl;
    logic        flush, ex_hold;
    logic        ex_valid;
    logic [31:0] ex_PC, ex_RD1, ex_RD2, ex_ImmG;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [1:0]  ex_ALUOp;
    logic [2:0]  ex_Funct3;
    logic [6:0]  ex_Funct7;
    logic [5:0]  ex_ctrl;
    logic        stall;
    logic [31:0] bubble_cnt;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_PC(id_PC),
        .id_RD1(id_RD1), .id_RD2(id_RD2), .id_ImmG(id_ImmG),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ALUOp(id_ALUOp), .id_Funct3(id_Funct3), .id_Funct7(id_Funct7),
        .id_ctrl(id_ctrl), .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_PC(ex_PC), .ex_RD1(ex_RD1), .ex_RD2(ex_RD2),
        .ex_ImmG(ex_ImmG), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ALUOp(ex_ALUOp), .ex_Funct3(ex_Funct3), .ex_Funct7(ex_Funct7),
        .ex_ctrl(ex_ctrl), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference EX-stage contents
    logic        m_valid;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [1:0]  m_aluop;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [5:0]  m_ctrl;
    logic [31:0] m_cnt;

    task automatic check_eq(input string tag, input chk_t obs, input chk_t exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic chk_t dut_vec();
        return chk_t'({ex_valid, ex_PC, ex_RD1, ex_RD2, ex_ImmG, ex_rs1, ex_rs2,
                       ex_rd, ex_ALUOp, ex_Funct3, ex_Funct7, ex_ctrl});
    endfunction

    function automatic chk_t model_vec();
        return chk_t'({m_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs1, m_rs2,
                       m_rd, m_aluop, m_f3, m_f7, m_ctrl});
    endfunction

    task automatic model_clear_ex();
        {m_valid, m_pc, m_rd1, m_rd2, m_imm, m_rs1, m_rs2, m_rd,
         m_aluop, m_f3, m_f7, m_ctrl} = '0;
    endtask

    // ID depends on an in-flight load that has not produced its data yet
    function automatic bit model_hazard();
        if (!(id_valid && m_valid && m_ctrl[4] && m_rd != 0)) return 1'b0;
        return (id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd);
    endfunction

    task automatic model_edge();
        bit hz;
        hz = model_hazard();
        if (flush) model_clear_ex();
        else if (ex_hold) ;
        else if (hz) begin
            model_clear_ex();
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid; m_pc = id_PC; m_rd1 = id_RD1; m_rd2 = id_RD2;
            m_imm = id_ImmG; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_aluop = id_ALUOp; m_f3 = id_Funct3; m_f7 = id_Funct7;
            m_ctrl = id_valid ? id_ctrl : 6'd0;
        end
    endtask

    task automatic rand_inputs(input bit allow_ctl);
        id_valid   = ($urandom_range(0, 7) != 0);
        id_PC      = $urandom; id_RD1 = $urandom; id_RD2 = $urandom; id_ImmG = $urandom;
        id_rs1     = 5'($urandom_range(0, 3));
        id_rs2     = 5'($urandom_range(0, 3));
        id_rd      = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom);
        id_use_rs2 = 1'($urandom);
        id_ALUOp   = 2'($urandom);
        id_Funct3  = 3'($urandom);
        id_Funct7  = 7'($urandom);
        id_ctrl    = 6'($urandom);
        flush      = allow_ctl && ($urandom_range(0, 7) == 0);
        ex_hold    = allow_ctl && ($urandom_range(0, 5) == 0);
    endtask

    // Called just after a falling edge with ID inputs set; ends at next falling edge.
    task automatic cycle(input string tag);
        #1;
        check_eq({tag, "_stall"}, chk_t'(stall),
                 chk_t'(ex_hold | (model_hazard() & ~flush)));
        @(posedge clk);
        model_edge();
        #1;
        check_eq({tag, "_ex"}, dut_vec(), model_vec());
        check_eq({tag, "_cnt"}, chk_t'(bubble_cnt), chk_t'(m_cnt));
        @(negedge clk);
    endtask

    // Asynchronous reset pulse asserted mid-cycle, released at a later falling edge.
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_clear_ex();
        m_cnt = '0;
        check_eq({tag, "_ex"}, dut_vec(), chk_t'(0));
        check_eq({tag, "_cnt"}, chk_t'(bubble_cnt), chk_t'(0));
        check_eq({tag, "_stall"}, chk_t'(stall), chk_t'(ex_hold));
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        rand_inputs(1'b0);
        id_valid = 1'b1; id_rd = rd; id_ctrl = 6'b110110;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    endtask

    task automatic set_consumer(input logic [4:0] rs2);
        rand_inputs(1'b0);
        id_valid = 1'b1; id_rs2 = rs2; id_use_rs2 = 1'b1;
        id_use_rs1 = 1'b0; id_rd = 5'd9; id_ctrl = 6'b100000;
    endtask

    initial begin
        reset = 1'b1;
        rand_inputs(1'b0);
        model_clear_ex();
        m_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("init_ex", dut_vec(), chk_t'(0));
        check_eq("init_cnt", chk_t'(bubble_cnt), chk_t'(0));
        reset = 1'b0;

        // Pass-through of an R-type SRA-like instruction
        rand_inputs(1'b0);
        id_valid = 1'b1; id_ALUOp = 2'b10; id_Funct3 = 3'b101; id_Funct7 = 7'b0100000;
        id_RD1 = 32'h8000_0000; id_rd = 5'd7; id_ctrl = 6'b100000;
        cycle("pass");
        check_eq("pass_rd1", chk_t'(ex_RD1), chk_t'(32'h8000_0000));
        check_eq("pass_f7", chk_t'({ex_valid, ex_ALUOp, ex_Funct3, ex_Funct7, ex_rd}),
                 chk_t'({1'b1, 2'b10, 3'b101, 7'b0100000, 5'd7}));

        // Asynchronous reset while EX is valid
        rand_inputs(1'b0);
        do_reset("rst");

        // Load-use: one bubble, then the consumer advances
        set_load(5'd5);
        cycle("lu_ld");
        set_consumer(5'd5);
        #1 check_eq("lu_stall1", chk_t'(stall), chk_t'(1));
        cycle("lu_hz");
        check_eq("lu_bubble", chk_t'({ex_valid, ex_ctrl, bubble_cnt}), chk_t'({1'b0, 6'd0, 32'd1}));
        cycle("lu_go");
        check_eq("lu_consumer", chk_t'({ex_valid, ex_rd}), chk_t'({1'b1, 5'd9}));

        // Negative hazards
        set_load(5'd0);
        cycle("neg_ld0");
        rand_inputs(1'b0);
        id_valid = 1'b1; id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        #1 check_eq("neg_rd0", chk_t'(stall), chk_t'(0));
        cycle("neg_rd0c");
        set_load(5'd3);
        cycle("neg_ld3");
        rand_inputs(1'b0);
        id_valid = 1'b1; id_rs1 = 5'd3; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        #1 check_eq("neg_nouse", chk_t'(stall), chk_t'(0));
        cycle("neg_nousec");
        rand_inputs(1'b0);
        id_valid = 1'b1; id_rd = 5'd3; id_ctrl = 6'b100000;
        cycle("neg_alu");
        set_consumer(5'd3);
        #1 check_eq("neg_nomr", chk_t'(stall), chk_t'(0));
        cycle("neg_nomrc");

        // Priority: flush + hold + hazard together, then hold alone
        set_load(5'd6);
        cycle("pri_ld");
        set_consumer(5'd6);
        flush = 1'b1; ex_hold = 1'b1;
        #1 check_eq("pri_stall", chk_t'(stall), chk_t'(1));
        cycle("pri_all");
        check_eq("pri_bubble", chk_t'({ex_valid, bubble_cnt}), chk_t'({1'b0, 32'd1}));
        set_load(5'd2);
        cycle("pri_ld2");
        for (int i = 0; i < 3; i++) begin
            rand_inputs(1'b0);
            ex_hold = 1'b1;
            cycle("hold");
        end

        // Saturation of the bubble counter
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.bubble_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 2; i++) begin
            set_load(5'd4);
            cycle("sat_ld");
            set_consumer(5'd4);
            cycle("sat_hz");
        end
        check_eq("sat_val", chk_t'(bubble_cnt), chk_t'(32'hFFFF_FFFF));

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
            else cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
